// File: rtl/i2c_slave_regfile_if.sv
// I2C pin bundle for the register-file target.
//   scl_i  : SCL as seen at the pad
//   sda_i  : SDA as seen at the pad (already wired-AND with every driver)
//   sda_oe : 1 = target pulls SDA low, 0 = target releases SDA
// The master modport is the bus/board side; the slave modport is the target.
interface i2c_slave_regfile_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a 7-bit address and a NUM_REGS x 8 register-file back end.
// Handles multi-byte writes and reads with an auto-incrementing pointer and
// repeated START. SCL/SDA are oversampled on clk1; SDA is driven open-drain.
//
// Ports:
//   clk1       system clock, at least 8x the SCL frequency
//   reset      asynchronous, active-high
//   bus        I2C pins (scl_i, sda_i in; sda_oe out)
//   reg_addr   current register pointer
//   reg_rdata  read data for reg_addr (combinational, valid 1 cycle after reg_addr changes)
//   reg_wr     1-cycle write strobe
//   reg_wdata  write data, valid while reg_wr is high
//   busy       high from address match until STOP
//
// State      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for START, bus otherwise ignored
// S_ADDR     | shifting in the address byte
// S_ADDR_ACK | acknowledging our address, then branching on R/W
// S_PTR      | shifting in the register pointer
// S_PTR_ACK  | acknowledging the pointer byte
// S_WR_DATA  | shifting in a write data byte
// S_WR_ACK   | acknowledging write data, pointer advances afterwards
// S_RD_DATA  | shifting out a read data byte
// S_RD_ACK   | sampling the master's ACK/NACK after a read byte
module i2c_slave_regfile #(
    parameter logic [6:0] MY_ADDR     = 7'h4A,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk1,
    input  logic                 reset,
    i2c_slave_regfile_if.slave   bus,
    output logic [PTR_W-1:0]     reg_addr,
    input  logic [7:0]           reg_rdata,
    output logic                 reg_wr,
    output logic [7:0]           reg_wdata,
    output logic                 busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             ack_ph, ack_ph_nxt;
    logic             sda_oe_q, sda_oe_nxt;
    logic [PTR_W-1:0] reg_addr_nxt, reg_addr_inc;
    logic             reg_wr_nxt;
    logic [7:0]       reg_wdata_nxt;
    logic             busy_nxt;

    logic [7:0] byte_in;
    logic       last_bit;
    logic       addr_match;

    // Synchronisers reset to 1 so an idle (pulled-up) bus produces no edges
    // when reset is released.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    // SCL must be high on both sides of the SDA change to count as START/STOP.
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign byte_in      = {shift[6:0], sda_s};
    assign last_bit     = (bit_cnt == 3'd7);
    assign addr_match   = (byte_in[7:1] == MY_ADDR) && (MY_ADDR != 7'h00);
    assign reg_addr_inc = (reg_addr == PTR_W'(NUM_REGS - 1)) ? '0 : reg_addr + PTR_W'(1);

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ack_ph    <= 1'b0;
            sda_oe_q  <= 1'b0;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            ack_ph    <= ack_ph_nxt;
            sda_oe_q  <= sda_oe_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wr    <= reg_wr_nxt;
            reg_wdata <= reg_wdata_nxt;
            busy      <= busy_nxt;
        end
    end

    assign bus.sda_oe = sda_oe_q;

    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = S_IDLE;
        end else if (start_det) begin
            state_nxt = S_ADDR;
        end else begin
            case (state)
                S_ADDR:     if (scl_rise && last_bit) state_nxt = addr_match ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK: if (scl_fall && ack_ph)   state_nxt = shift[0] ? S_RD_DATA : S_PTR;
                S_PTR:      if (scl_rise && last_bit) state_nxt = S_PTR_ACK;
                S_PTR_ACK:  if (scl_fall && ack_ph)   state_nxt = S_WR_DATA;
                S_WR_DATA:  if (scl_rise && last_bit) state_nxt = S_WR_ACK;
                S_WR_ACK:   if (scl_fall && ack_ph)   state_nxt = S_WR_DATA;
                S_RD_DATA:  if (scl_rise && last_bit) state_nxt = S_RD_ACK;
                S_RD_ACK: begin
                    if (scl_rise && sda_s)      state_nxt = S_IDLE;
                    else if (scl_fall && ack_ph) state_nxt = S_RD_DATA;
                end
                default:    state_nxt = state;
            endcase
        end
    end

    // ack_ph splits each ACK bit: 0 = still in the high phase of the 8th data
    // bit, 1 = the ACK clock low phase has begun.
    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        ack_ph_nxt    = ack_ph;
        sda_oe_nxt    = sda_oe_q;
        reg_addr_nxt  = reg_addr;
        reg_wr_nxt    = 1'b0;
        reg_wdata_nxt = reg_wdata;
        busy_nxt      = busy;

        if (stop_det) begin
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
            ack_ph_nxt  = 1'b0;
        end else if (start_det) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 3'd0;
            ack_ph_nxt  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            ack_ph_nxt = 1'b0;
                            if (state == S_ADDR) begin
                                busy_nxt = addr_match;
                            end else if (state == S_PTR) begin
                                reg_addr_nxt = byte_in[PTR_W-1:0];
                            end else begin
                                reg_wdata_nxt = byte_in;
                                reg_wr_nxt    = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe_nxt = 1'b1;
                            ack_ph_nxt = 1'b1;
                        end else begin
                            ack_ph_nxt  = 1'b0;
                            bit_cnt_nxt = 3'd0;
                            sda_oe_nxt  = 1'b0;
                            if (state == S_WR_ACK) begin
                                reg_addr_nxt = reg_addr_inc;
                            end
                            // Read direction: first bit goes out on this same fall.
                            if (state == S_ADDR_ACK && shift[0]) begin
                                shift_nxt  = reg_rdata;
                                sda_oe_nxt = ~reg_rdata[7];
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            ack_ph_nxt = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_nxt  = {shift[6:0], shift[7]};
                        sda_oe_nxt = ~shift[6];
                    end
                end
                S_RD_ACK: begin
                    if (scl_fall) begin
                        if (!ack_ph) begin
                            sda_oe_nxt = 1'b0;
                            ack_ph_nxt = 1'b1;
                        end else begin
                            // Pointer moved at the ACK rise, so reg_rdata has settled.
                            shift_nxt   = reg_rdata;
                            sda_oe_nxt  = ~reg_rdata[7];
                            bit_cnt_nxt = 3'd0;
                            ack_ph_nxt  = 1'b0;
                        end
                    end else if (scl_rise && !sda_s) begin
                        reg_addr_nxt = reg_addr_inc;
                    end
                end
                default: begin
                    bit_cnt_nxt = bit_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
module tb_i2c_slave_regfile;

    localparam int Q = 6;

    logic clk1 = 1'b0;
    logic reset;
    logic m_scl, m_sda;
    wire  sda_line;

    always #5 clk1 = ~clk1;

    i2c_slave_regfile_if bus_a();
    i2c_slave_regfile_if bus_b();

    assign sda_line     = m_sda & ~bus_a.sda_oe & ~bus_b.sda_oe;
    assign bus_a.scl_i  = m_scl;
    assign bus_a.sda_i  = sda_line;
    assign bus_b.scl_i  = m_scl;
    assign bus_b.sda_i  = sda_line;

    logic [3:0] addr_a;
    logic [7:0] rdata_a, wdata_a;
    logic       wr_a, busy_a;
    logic [1:0] addr_b;
    logic [7:0] rdata_b, wdata_b;
    logic       wr_b, busy_b;

    logic [7:0] regs_a [16];
    logic [7:0] regs_b [4];

    assign rdata_a = regs_a[addr_a];
    assign rdata_b = regs_b[addr_b];

    i2c_slave_regfile #(.MY_ADDR(7'h4A), .NUM_REGS(16), .PTR_W(4), .SYNC_STAGES(2)) dut_a (
        .clk1(clk1), .reset(reset), .bus(bus_a),
        .reg_addr(addr_a), .reg_rdata(rdata_a), .reg_wr(wr_a),
        .reg_wdata(wdata_a), .busy(busy_a)
    );

    i2c_slave_regfile #(.MY_ADDR(7'h21), .NUM_REGS(4), .PTR_W(2), .SYNC_STAGES(3)) dut_b (
        .clk1(clk1), .reset(reset), .bus(bus_b),
        .reg_addr(addr_b), .reg_rdata(rdata_b), .reg_wr(wr_b),
        .reg_wdata(wdata_b), .busy(busy_b)
    );

    int         wr_cnt_a = 0, wr_cnt_b = 0, oe_cnt_a = 0;
    logic [3:0] wr_addr_a = 4'h0;
    logic [7:0] wr_data_a = 8'h00;
    logic [1:0] wr_addr_b = 2'h0;
    logic [7:0] wr_data_b = 8'h00;

    always @(posedge clk1) begin
        if (wr_a) begin
            wr_cnt_a  <= wr_cnt_a + 1;
            wr_addr_a <= addr_a;
            wr_data_a <= wdata_a;
        end
        if (wr_b) begin
            wr_cnt_b  <= wr_cnt_b + 1;
            wr_addr_b <= addr_b;
            wr_data_b <= wdata_b;
        end
        if (bus_a.sda_oe) oe_cnt_a <= oe_cnt_a + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic qdly();
        repeat (Q) @(posedge clk1);
        #1;
    endtask

    task automatic start_cond();
        m_sda = 1'b1; qdly();
        m_scl = 1'b1; qdly();
        m_sda = 1'b0; qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; qdly();
        m_scl = 1'b1; qdly();
        m_sda = 1'b1; qdly();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    qdly();
        m_scl = 1'b1; qdly(); qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1; qdly();
        m_scl = 1'b1; qdly();
        ack = ~sda_line;
        qdly();
        m_scl = 1'b0; qdly();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        d = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            qdly();
            m_scl = 1'b1; qdly();
            d = {d[6:0], sda_line};
            qdly();
            m_scl = 1'b0; qdly();
        end
        m_sda = ~mack; qdly();
        m_scl = 1'b1;  qdly(); qdly();
        m_scl = 1'b0;  qdly();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         w0, o0;

        for (int i = 0; i < 16; i++) regs_a[i] = 8'(i * 17);
        regs_a[15] = 8'hC3;
        regs_a[0]  = 8'h3C;
        regs_a[1]  = 8'h96;
        regs_a[6]  = 8'h9A;
        for (int i = 0; i < 4; i++) regs_b[i] = 8'h00;

        reset = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(posedge clk1);
        #1;
        chk_eq("rst_sda_oe", bus_a.sda_oe, 1'b0);
        chk_eq("rst_reg_wr", wr_a, 1'b0);
        chk_eq("rst_wdata", wdata_a, 8'h00);
        chk_eq("rst_addr", addr_a, 4'h0);
        chk_eq("rst_busy", busy_a, 1'b0);
        reset = 1'b0;
        qdly();

        // 1: pointer 3, two data bytes
        w0 = wr_cnt_a;
        start_cond();
        write_byte(8'h94, ack); chk_eq("t1_ack_addr", ack, 1'b1);
        chk_eq("t1_busy", busy_a, 1'b1);
        write_byte(8'h03, ack); chk_eq("t1_ack_ptr", ack, 1'b1);
        chk_eq("t1_ptr", addr_a, 4'h3);
        write_byte(8'hA5, ack); chk_eq("t1_ack_d0", ack, 1'b1);
        chk_eq("t1_wr_cnt0", wr_cnt_a - w0, 1);
        chk_eq("t1_wr_addr0", wr_addr_a, 4'h3);
        chk_eq("t1_wr_data0", wr_data_a, 8'hA5);
        write_byte(8'h5A, ack); chk_eq("t1_ack_d1", ack, 1'b1);
        chk_eq("t1_wr_cnt1", wr_cnt_a - w0, 2);
        chk_eq("t1_wr_addr1", wr_addr_a, 4'h4);
        chk_eq("t1_wr_data1", wr_data_a, 8'h5A);
        stop_cond();
        chk_eq("t1_busy_end", busy_a, 1'b0);
        chk_eq("t1_addr_end", addr_a, 4'h5);

        // 2: wrong address
        w0 = wr_cnt_a;
        o0 = oe_cnt_a;
        start_cond();
        write_byte(8'h96, ack); chk_eq("t2_nack_addr", ack, 1'b0);
        chk_eq("t2_busy", busy_a, 1'b0);
        write_byte(8'h00, ack); chk_eq("t2_nack_data", ack, 1'b0);
        stop_cond();
        chk_eq("t2_oe_cnt", oe_cnt_a - o0, 0);
        chk_eq("t2_wr_cnt", wr_cnt_a - w0, 0);

        // 3: pointer 15, repeated START, read three bytes with wrap
        start_cond();
        write_byte(8'h94, ack); chk_eq("t3_ack_addr", ack, 1'b1);
        write_byte(8'h0F, ack); chk_eq("t3_ack_ptr", ack, 1'b1);
        start_cond();
        write_byte(8'h95, ack); chk_eq("t3_ack_raddr", ack, 1'b1);
        read_byte(1'b1, rd); chk_eq("t3_rd0", rd, 8'hC3);
        read_byte(1'b1, rd); chk_eq("t3_rd1", rd, 8'h3C);
        read_byte(1'b0, rd); chk_eq("t3_rd2", rd, 8'h96);
        chk_eq("t3_addr_nack", addr_a, 4'h1);
        chk_eq("t3_oe_released", bus_a.sda_oe, 1'b0);
        stop_cond();
        chk_eq("t3_busy_end", busy_a, 1'b0);

        // 4: partial data byte cut by STOP, then a normal frame
        w0 = wr_cnt_a;
        start_cond();
        write_byte(8'h94, ack);
        write_byte(8'h02, ack); chk_eq("t4_ack_ptr", ack, 1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        stop_cond();
        chk_eq("t4_wr_none", wr_cnt_a - w0, 0);
        chk_eq("t4_busy", busy_a, 1'b0);
        chk_eq("t4_oe", bus_a.sda_oe, 1'b0);
        start_cond();
        write_byte(8'h94, ack); chk_eq("t4_ack_addr2", ack, 1'b1);
        write_byte(8'h05, ack);
        write_byte(8'h77, ack); chk_eq("t4_ack_d", ack, 1'b1);
        stop_cond();
        chk_eq("t4_wr_cnt", wr_cnt_a - w0, 1);
        chk_eq("t4_wr_addr", wr_addr_a, 4'h5);
        chk_eq("t4_wr_data", wr_data_a, 8'h77);

        // 5: reset while driving read bit 5 of reg[6] = 0x9A
        start_cond();
        write_byte(8'h94, ack);
        write_byte(8'h06, ack);
        start_cond();
        write_byte(8'h95, ack); chk_eq("t5_ack_raddr", ack, 1'b1);
        m_sda = 1'b1;
        for (int i = 0; i < 2; i++) begin
            qdly(); m_scl = 1'b1; qdly(); qdly(); m_scl = 1'b0; qdly();
        end
        qdly(); m_scl = 1'b1; qdly();
        chk_eq("t5_oe_before", bus_a.sda_oe, 1'b1);
        reset = 1'b1;
        #1;
        chk_eq("t5_oe_async", bus_a.sda_oe, 1'b0);
        repeat (3) @(posedge clk1);
        #1;
        reset = 1'b0;
        chk_eq("t5_busy", busy_a, 1'b0);
        chk_eq("t5_addr", addr_a, 4'h0);
        qdly(); m_scl = 1'b0; qdly();
        stop_cond();
        w0 = wr_cnt_a;
        start_cond();
        write_byte(8'h94, ack); chk_eq("t5_ack_next", ack, 1'b1);
        write_byte(8'h09, ack);
        write_byte(8'h3E, ack);
        stop_cond();
        chk_eq("t5_wr_addr", wr_addr_a, 4'h9);
        chk_eq("t5_wr_data", wr_data_a, 8'h3E);
        chk_eq("t5_wr_cnt", wr_cnt_a - w0, 1);

        // 6: 4-register target, 3-stage sync, address 0x21
        w0 = wr_cnt_b;
        start_cond();
        write_byte(8'h42, ack); chk_eq("t6_ack_addr", ack, 1'b1);
        write_byte(8'h07, ack); chk_eq("t6_ack_ptr", ack, 1'b1);
        chk_eq("t6_ptr", addr_b, 2'h3);
        write_byte(8'hB4, ack);
        chk_eq("t6_wr_addr0", wr_addr_b, 2'h3);
        chk_eq("t6_wr_data0", wr_data_b, 8'hB4);
        chk_eq("t6_wrap", addr_b, 2'h0);
        write_byte(8'h4D, ack);
        chk_eq("t6_wr_addr1", wr_addr_b, 2'h0);
        chk_eq("t6_wr_data1", wr_data_b, 8'h4D);
        stop_cond();
        chk_eq("t6_wr_cnt", wr_cnt_b - w0, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
